// File: rtl/icache_line_requester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_line_requester: direct-mapped read-only I-cache, 16-byte lines,    |
// | one outstanding line refill. Define ICACHE_PERF_CNT_EN for hit/miss cnts. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module icache_line_requester #(
    parameter int INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_req,
    input  logic [31:0]  inst_addr,
    input  logic         flush,
    output logic         inst_ready,
    output logic         inst_valid,
    output logic [31:0]  inst_data,
    output logic         memory_valid_for_ICache,
    output logic [31:0]  load_inst_addr,
    input  logic         memory_ready_for_ICache,
    input  logic [127:0] inst_from_mem
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int DEPTH    = 1 << INDEX_BITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;
    localparam logic [1:0] S_FILL   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [31:2]         addr_q, addr_d;
    logic [31:4]         load_addr_q, load_addr_d;
    logic [127:0]        line_q, line_d;
    logic                inst_valid_q, inst_valid_d;
    logic [31:0]         inst_data_q, inst_data_d;
    logic                flush_pend_q, flush_pend_d;

    logic [DEPTH-1:0]    valid_q;
    logic                rd_valid_q;
    logic [TAG_BITS-1:0] rd_tag_q;
    logic [127:0]        rd_data_q;
    logic [TAG_BITS-1:0] tag_mem  [DEPTH];
    logic [127:0]        data_mem [DEPTH];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [6:0]            word_sel;
    logic                  tag_match;
    logic                  fill_we;
    logic                  unused_addr_bits;

    assign rd_idx           = inst_addr[3+INDEX_BITS:4];
    assign fill_idx         = addr_q[3+INDEX_BITS:4];
    assign req_tag          = addr_q[31:4+INDEX_BITS];
    assign word_sel         = {addr_q[3:2], 5'b0};
    assign tag_match        = rd_valid_q && (rd_tag_q == req_tag);
    assign fill_we          = (state_q == S_FILL);
    assign unused_addr_bits = ^inst_addr[1:0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        load_addr_d  = load_addr_q;
        line_d       = line_q;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                if (inst_req) begin
                    addr_d  = inst_addr[31:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (tag_match) begin
                    inst_valid_d = 1'b1;
                    inst_data_d  = rd_data_q[word_sel +: 32];
                    state_d      = S_IDLE;
                end else begin
                    load_addr_d = addr_q[31:4];
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (memory_ready_for_ICache) begin
                    line_d  = inst_from_mem;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Answer from the captured line; the array write lands this same edge.
                inst_valid_d = 1'b1;
                inst_data_d  = line_q[word_sel +: 32];
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            load_addr_q  <= '0;
            line_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            load_addr_q  <= load_addr_d;
            line_q       <= line_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Flush is applied after the fill write so a coincident flush leaves the line invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= valid_q[rd_idx];
            if (fill_we) begin
                valid_q[fill_idx] <= ~flush_pend_q;
            end
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= req_tag;
            data_mem[fill_idx] <= line_q;
        end
        rd_tag_q  <= tag_mem[rd_idx];
        rd_data_q <= data_mem[rd_idx];
    end

`ifdef ICACHE_PERF_CNT_EN
    logic        lookup_hit;
    logic        lookup_miss;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    assign lookup_hit  = (state_q == S_LOOKUP) && tag_match;
    assign lookup_miss = (state_q == S_LOOKUP) && !tag_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (lookup_miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign inst_ready              = (state_q == S_IDLE);
    assign inst_valid              = inst_valid_q;
    assign inst_data               = inst_data_q;
    assign memory_valid_for_ICache = (state_q == S_REFILL) && !memory_ready_for_ICache;
    assign load_inst_addr          = {load_addr_q, 4'h0};

endmodule
`default_nettype wire

// File: tb/tb_icache_line_requester.sv
`default_nettype none
// tb_icache_line_requester: directed and randomized fetches checked against a
// line-level cache model with a latency-configurable memory responder.
module tb_icache_line_requester;

    localparam int IB = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inst_req = 1'b0;
    logic [31:0]  inst_addr = '0;
    logic         flush = 1'b0;
    logic         inst_ready;
    logic         inst_valid;
    logic [31:0]  inst_data;
    logic         memory_valid_for_ICache;
    logic [31:0]  load_inst_addr;
    logic         memory_ready_for_ICache = 1'b0;
    logic [127:0] inst_from_mem = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int failures = 0;

    int          mem_lat = 3;
    bit          mem_hold = 1'b0;
    int          mem_eps = 0;
    logic [31:0] ep_addr = '0;
    int          cnt = 0;
    bit          prev_v = 1'b0;
    bit          post_rdy = 1'b0;
    bit          prev_iv = 1'b0;

    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    int          n_hit = 0;
    int          n_miss = 0;

    logic [19:0] tpool [4] = '{20'h80000, 20'h80001, 20'h12345, 20'hFFFFF};
    logic [7:0]  ipool [4] = '{8'h10, 8'h11, 8'h20, 8'hFF};

    icache_line_requester #(.INDEX_BITS(IB)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .inst_req                (inst_req),
        .inst_addr               (inst_addr),
        .flush                   (flush),
        .inst_ready              (inst_ready),
        .inst_valid              (inst_valid),
        .inst_data               (inst_data),
        .memory_valid_for_ICache (memory_valid_for_ICache),
        .load_inst_addr          (load_inst_addr),
        .memory_ready_for_ICache (memory_ready_for_ICache),
        .inst_from_mem           (inst_from_mem)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count               (hit_count),
        .miss_count              (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backing memory contents: a fixed test line plus an address hash elsewhere.
    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        if (la == 28'h800_0010) return 128'h4444_3333_2222_1111_0000_0000_BBBB_AAAA;
        for (int w = 0; w < 4; w++)
            l[32*w +: 32] = ({4'h0, la} * 32'h9E37_79B1) + (32'(w) * 32'h1111_1111) + 32'h5A5A_0001;
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [127:0] l;
        l = line_of(a[31:4]);
        return l[{a[3:2], 5'b0} +: 32];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    // Memory responder: ready pulse after mem_lat cycles of valid, plus handshake checks.
    always @(negedge clk) begin
        memory_ready_for_ICache = 1'b0;
        if (post_rdy) begin
            chk("valid_after_ready", 128'(memory_valid_for_ICache), 128'(0));
            post_rdy = 1'b0;
        end
        if (memory_valid_for_ICache) begin
            if (!prev_v) begin
                mem_eps++;
                ep_addr = load_inst_addr;
            end else begin
                chk("addr_stable", 128'(load_inst_addr), 128'(ep_addr));
            end
            chk("ready_low_refill", 128'(inst_ready), 128'(0));
            if (!mem_hold && cnt >= mem_lat) begin
                cnt = 0;
                prev_v = 1'b0;
                post_rdy = 1'b1;
                inst_from_mem = line_of(load_inst_addr[31:4]);
                memory_ready_for_ICache = 1'b1;
                #1 chk("valid_in_ready", 128'(memory_valid_for_ICache), 128'(0));
            end else begin
                cnt++;
                prev_v = 1'b1;
            end
        end else begin
            cnt = 0;
            prev_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (inst_valid) chk("valid_not_back_to_back", 128'(prev_iv), 128'(0));
        prev_iv = inst_valid;
    end

    // fmode: 0 none, 1 flush in the lookup cycle, 2 flush somewhere in refill/fill (misses only).
    task automatic fetch(input logic [31:0] a, input int fmode);
        int          t;
        int          w;
        int          eps0;
        int          flush_at;
        bit          got;
        bit          exp_hit;
        logic [7:0]  idx;
        logic [19:0] tg;
        idx = a[11:4];
        tg  = a[31:12];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        flush_at = 0;
        if (fmode == 1) flush_at = 1;
        else if (fmode == 2 && !exp_hit) flush_at = $urandom_range(2, 3 + mem_lat);
        w = 0;
        while (!inst_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 128'(inst_ready), 128'(1));
        eps0 = mem_eps;
        inst_addr = a;
        inst_req = 1'b1;
        got = 1'b0;
        t = 0;
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            if (t == 1) inst_req = 1'b0;
            flush = (flush_at != 0 && t == flush_at);
            if (inst_valid) got = 1'b1;
        end
        flush = 1'b0;
        chk("fetch_done", 128'(got), 128'(1));
        chk("inst_data", 128'(inst_data), 128'(word_of(a)));
        if (exp_hit) begin
            n_hit++;
            chk("hit_latency", 128'(t), 128'(2));
            chk("hit_no_mem_req", 128'(mem_eps - eps0), 128'(0));
        end else begin
            n_miss++;
            chk("miss_one_req", 128'(mem_eps - eps0), 128'(1));
            chk("miss_line_addr", 128'(ep_addr), 128'({a[31:4], 4'h0}));
        end
        if (flush_at != 0) model_clear();
        if (!exp_hit && flush_at <= 1) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          fm;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_inst_ready", 128'(inst_ready), 128'(1));
        chk("rst_inst_valid", 128'(inst_valid), 128'(0));
        chk("rst_inst_data", 128'(inst_data), 128'(0));
        chk("rst_mem_valid", 128'(memory_valid_for_ICache), 128'(0));
        chk("rst_load_addr", 128'(load_inst_addr), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        mem_lat = 6;
        fetch(32'h8000_0104, 0);
        fetch(32'h8000_010C, 0);
        chk("cold_hit_word", 128'(inst_data), 128'(32'h4444_3333));

        mem_lat = 2;
        fetch(32'h8000_0000, 0);
        fetch(32'h8000_1000, 0);
        fetch(32'h8000_0000, 0);

        mem_lat = 20;
        fetch(32'h8000_2040, 0);

        mem_lat = 3;
        fetch(32'h8000_0200, 0);
        do_flush();
        fetch(32'h8000_0200, 0);

        mem_lat = 8;
        fetch(32'h8000_0400, 2);
        fetch(32'h8000_0404, 0);

        mem_hold = 1'b1;
        inst_addr = 32'h8000_0500;
        inst_req = 1'b1;
        @(negedge clk);
        inst_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("refill_before_rst", 128'(memory_valid_for_ICache), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_mem_valid", 128'(memory_valid_for_ICache), 128'(0));
        chk("midrst_inst_ready", 128'(inst_ready), 128'(1));
        chk("midrst_inst_valid", 128'(inst_valid), 128'(0));
        chk("midrst_load_addr", 128'(load_inst_addr), 128'(0));
        mem_hold = 1'b0;
        model_clear();
        n_hit = 0;
        n_miss = 0;

        mem_lat = 2;
        fetch(32'h8000_0104, 0);
        fetch(32'h8000_0108, 0);
        fetch(32'h8000_010C, 0);
        fetch(32'h8000_0100, 0);
        fetch(32'h8000_0300, 0);
        fetch(32'h8000_0304, 0);
        fetch(32'h8000_0308, 0);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hits_5", 128'(hit_count), 128'(32'd5));
        chk("perf_misses_2", 128'(miss_count), 128'(32'd2));
`endif

        for (int i = 0; i < 60; i++) begin
            a = {tpool[$urandom_range(0, 3)], ipool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'b00};
            mem_lat = $urandom_range(1, 5);
            if ($urandom_range(0, 9) == 0) do_flush();
            fm = 0;
            if ($urandom_range(0, 7) == 0) fm = 1;
            else if ($urandom_range(0, 4) == 0) fm = 2;
            fetch(a, fm);
        end
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hits_total", 128'(hit_count), 128'(n_hit));
        chk("perf_misses_total", 128'(miss_count), 128'(n_miss));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
